// File: rtl/hs_talker_sync.sv
// rtl/hs_talker_sync.sv - req/ack talker with ack synchronizer, 2/4-phase signalling and watchdog
module hs_talker_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PHASE4      = 1,
  parameter int TIMEOUT     = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_err,
  output logic              ready,
  output logic              busy,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, REL, ERR} state_t;

  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state, state_n;
  state_t              ret, ret_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                ack_s;
  logic [CNT_W-1:0]    wd, wd_n, wd_inc;
  logic                req_n, done_n, err_n;
  logic [DATA_W-1:0]   data_n;
  logic                req_exit;
  logic                wd_expired;

  // Multi-flop synchronizer: ack_in only ever reaches the FSM through ack_s.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s = sync[SYNC_STAGES-1];

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // Saturating increment, and expiry only when the watchdog is enabled.
  assign wd_inc     = (wd == {CNT_W{1'b1}}) ? wd : wd + 1'b1;
  assign wd_expired = WD_EN && (wd >= WD_LAST);
  assign req_exit   = (PHASE4 != 0) ? ack_s : (ack_s == req_out);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ret         <= REQ;
      req_out     <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
    end else begin
      state       <= state_n;
      ret         <= ret_n;
      req_out     <= req_n;
      data_out    <= data_n;
      done        <= done_n;
      timeout_err <= err_n;
      wd          <= wd_n;
    end
  end

  // Next-state and next-output decode; exit conditions take priority over expiry.
  always_comb begin
    state_n = state;
    ret_n   = ret;
    req_n   = req_out;
    data_n  = data_out;
    done_n  = 1'b0;
    err_n   = timeout_err;
    wd_n    = wd;
    unique case (state)
      IDLE: begin
        if (start) begin
          data_n  = data_in;
          req_n   = (PHASE4 != 0) ? 1'b1 : ~req_out;
          wd_n    = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        if (req_exit) begin
          wd_n = '0;
          if (PHASE4 != 0) begin
            req_n   = 1'b0;
            state_n = REL;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (wd_expired) begin
          ret_n   = REQ;
          err_n   = 1'b1;
          state_n = ERR;
        end else if (WD_EN) begin
          wd_n = wd_inc;
        end
      end
      REL: begin
        if (!ack_s) begin
          wd_n    = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (wd_expired) begin
          ret_n   = REL;
          err_n   = 1'b1;
          state_n = ERR;
        end else if (WD_EN) begin
          wd_n = wd_inc;
        end
      end
      ERR: begin
        if (clear_err) begin
          err_n   = 1'b0;
          wd_n    = '0;
          state_n = ret;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hs_talker_sync.sv
// tb/tb_hs_talker_sync.sv - self-checking bench for hs_talker_sync (4-phase and 2-phase instances)
module tb_hs_talker_sync;

  localparam int SYNC4 = 2;
  localparam int SYNC2 = 3;
  localparam int TO4   = 10;
  localparam int BOUND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start4, clr4, ack4, ready4, busy4, req4, done4, err4;
  logic [7:0] din4, dout4;
  logic       start2, clr2, ack2, ready2, busy2, req2, done2, err2;
  logic [7:0] din2, dout2;

  int errors = 0;
  int checks = 0;

  hs_talker_sync #(.DATA_W(8), .SYNC_STAGES(SYNC4), .PHASE4(1), .TIMEOUT(TO4), .CNT_W(16)) u4 (
    .clk(clk), .reset(reset), .start(start4), .data_in(din4), .clear_err(clr4),
    .ready(ready4), .busy(busy4), .req_out(req4), .data_out(dout4), .ack_in(ack4),
    .done(done4), .timeout_err(err4)
  );

  hs_talker_sync #(.DATA_W(8), .SYNC_STAGES(SYNC2), .PHASE4(0), .TIMEOUT(0), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(din2), .clear_err(clr2),
    .ready(ready2), .busy(busy2), .req_out(req2), .data_out(dout2), .ack_in(ack2),
    .done(done2), .timeout_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req4(input logic v, output int n);
    n = 0;
    while (n < BOUND) begin
      tick();
      n++;
      if (req4 === v) break;
    end
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (n < BOUND) begin
      tick();
      n++;
      if (done4 === 1'b1) break;
    end
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    while (n < BOUND) begin
      tick();
      n++;
      if (done2 === 1'b1) break;
    end
  endtask

  // One complete 4-phase transfer; w busy cycles carry ignored start pulses with junk data.
  task automatic xfer4(input logic [7:0] d, input int w, input bit junk_always);
    int n;
    din4 = d; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("req4_rise", 32'(req4), 32'd1);
    chk("dout4_capture", 32'(dout4), 32'(d));
    chk("ready4_drop", 32'(ready4), 32'd0);
    chk("busy4_set", 32'(busy4), 32'd1);
    for (int i = 0; i < w; i++) begin
      start4 = junk_always ? 1'b1 : 1'($urandom);
      din4   = 8'hFF;
      tick();
    end
    start4 = 1'b0;
    chk("dout4_hold_busy", 32'(dout4), 32'(d));
    chk("req4_hold_busy", 32'(req4), 32'd1);
    ack4 = 1'b1;
    wait_req4(1'b0, n);
    chk("req4_fall_latency", 32'(n), 32'(SYNC4 + 1));
    ack4 = 1'b0;
    wait_done4(n);
    chk("done4_latency", 32'(n), 32'(SYNC4 + 1));
    chk("ready4_with_done", 32'(ready4), 32'd1);
    chk("dout4_after", 32'(dout4), 32'(d));
    tick();
    chk("done4_one_cycle", 32'(done4), 32'd0);
    chk("err4_clean", 32'(err4), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int         n;
    logic       par2;
    logic [7:0] cur2, nxt2;

    reset = 1'b0;
    start4 = 1'b0; clr4 = 1'b0; ack4 = 1'b0; din4 = 8'h00;
    start2 = 1'b0; clr2 = 1'b0; ack2 = 1'b0; din2 = 8'h00;
    tick(); tick();
    chk("rst_ready4", 32'(ready4), 32'd1);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_req4", 32'(req4), 32'd0);
    chk("rst_dout4", 32'(dout4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_err4", 32'(err4), 32'd0);
    chk("rst_ready2", 32'(ready2), 32'd1);
    chk("rst_req2", 32'(req2), 32'd0);
    reset = 1'b1;
    tick();

    // 4-phase: directed 0xA5 with busy start pulses, then randomized transfers.
    xfer4(8'hA5, 3, 1'b1);
    for (int i = 0; i < 8; i++) xfer4(8'($urandom_range(0, 255)), $urandom_range(0, 4), 1'b0);

    // 2-phase: 0x11 then 0x22 back-to-back, then randomized back-to-back chain.
    par2 = 1'b0;
    cur2 = 8'h11;
    din2 = cur2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    par2 = ~par2;
    chk("req2_first", 32'(req2), 32'(par2));
    chk("dout2_first", 32'(dout2), 32'(cur2));
    chk("ready2_drop", 32'(ready2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      ack2 = par2;
      wait_done2(n);
      chk("done2_latency", 32'(n), 32'(SYNC2 + 1));
      chk("ready2_with_done", 32'(ready2), 32'd1);
      chk("dout2_hold", 32'(dout2), 32'(cur2));
      nxt2 = (i == 0) ? 8'h22 : 8'($urandom_range(0, 255));
      din2 = nxt2; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      par2 = ~par2;
      cur2 = nxt2;
      chk("req2_toggle", 32'(req2), 32'(par2));
      chk("dout2_b2b", 32'(dout2), 32'(cur2));
      chk("ready2_b2b", 32'(ready2), 32'd0);
      chk("done2_one_cycle", 32'(done2), 32'd0);
    end
    ack2 = par2;
    wait_done2(n);
    chk("done2_last_latency", 32'(n), 32'(SYNC2 + 1));
    tick();
    chk("err2_never", 32'(err2), 32'd0);

    // Watchdog expiry in REQ, sticky error, clear and normal completion.
    din4 = 8'h3C; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (n < BOUND) begin
      tick();
      n++;
      if (err4 === 1'b1) break;
    end
    chk("timeout_cycles", 32'(n), 32'(TO4));
    chk("timeout_req_held", 32'(req4), 32'd1);
    chk("timeout_dout_held", 32'(dout4), 32'h3C);
    chk("timeout_busy", 32'(ready4), 32'd0);
    repeat (3) tick();
    chk("timeout_sticky", 32'(err4), 32'd1);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("clear_err", 32'(err4), 32'd0);
    chk("clear_req_held", 32'(req4), 32'd1);
    ack4 = 1'b1;
    wait_req4(1'b0, n);
    chk("retry_req_fall", 32'(n), 32'(SYNC4 + 1));
    ack4 = 1'b0;
    wait_done4(n);
    chk("retry_done", 32'(n), 32'(SYNC4 + 1));
    tick();

    // Expiry race: ack_s arrives on the very edge the watchdog expires.
    din4 = 8'hC3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (TO4 - SYNC4 - 1) tick();
    ack4 = 1'b1;
    repeat (SYNC4 + 1) tick();
    chk("race_req_fall", 32'(req4), 32'd0);
    chk("race_no_err", 32'(err4), 32'd0);
    ack4 = 1'b0;
    wait_done4(n);
    chk("race_done", 32'(n), 32'(SYNC4 + 1));
    tick();

    // Asynchronous reset while in REL.
    din4 = 8'h5A; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    ack4 = 1'b1;
    wait_req4(1'b0, n);
    chk("rel_dout", 32'(dout4), 32'h5A);
    reset = 1'b0;
    #1;
    chk("arst_dout", 32'(dout4), 32'd0);
    chk("arst_ready", 32'(ready4), 32'd1);
    chk("arst_busy", 32'(busy4), 32'd0);
    chk("arst_done", 32'(done4), 32'd0);
    chk("arst_err", 32'(err4), 32'd0);
    chk("arst_req", 32'(req4), 32'd0);
    ack4 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_ready", 32'(ready4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_talker_sync.md
Name: hs_talker_sync

Overview:
Parametrised single-domain talker for the req/ack clock-crossing link. It captures a DATA_W-bit word on start and drives a bundled-data request to a listener in another clock domain. It receives the listener's asynchronous acknowledge through a configurable-depth synchronizer. It supports 4-phase (return-to-zero) and 2-phase (toggle) signalling, plus a watchdog timeout with sticky error and retry. It is the next-generation replacement for the fixed 1-bit, 4-phase, 2-flop talker.

Parameters:
DATA_W, 8, width of the bundled data word (>=1)
SYNC_STAGES, 2, flops in the ack_in synchronizer chain (>=2)
PHASE4, 1, 1 = 4-phase RZ protocol; 0 = 2-phase NRZ toggle protocol
TIMEOUT, 0, cycles allowed in a wait state before error; 0 = watchdog disabled
CNT_W, 16, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request to send data_in; sampled only when ready=1
data_in  in  DATA_W  word captured on an accepted start
clear_err  in  1  clears timeout_err and resumes waiting; only honoured in ERR
ready  out  1  1 when in IDLE and able to accept start
busy  out  1  inverse of ready
req_out  out  1  request to listener domain (registered)
data_out  out  DATA_W  captured word (registered); stable while busy=1
ack_in  in  1  asynchronous acknowledge from the listener domain
done  out  1  one-cycle pulse when a transfer completes
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; req_out=0; data_out=0; done=0; timeout_err=0; sync chain=0; watchdog=0; ready=1; busy=0.
- ack_in passes through SYNC_STAGES flops to give ack_s. The FSM uses only ack_s; ack_in never reaches logic directly. Any ack_in edge is visible to the FSM SYNC_STAGES edges later.
- States: IDLE, REQ (wait for ack assertion or toggle), REL (4-phase only: wait for ack release), ERR.
- ready = (state==IDLE), decoded from registered state only.
- IDLE + start=1:
  - data_out<=data_in.
  - req_out<=1 if PHASE4=1; req_out<=~req_out if PHASE4=0.
  - watchdog<=0; next state REQ.
  - ready drops on the following cycle.
- IDLE + start=0: hold all state.
- REQ, PHASE4=1: on ack_s=1, req_out<=0 and go to REL.
- REQ, PHASE4=0: on ack_s==req_out, go to IDLE and pulse done.
- REL: on ack_s=0, go to IDLE and pulse done.
- done is registered. It is high for exactly one cycle, the same cycle ready returns to 1.
- start sampled in the cycle where done=1 is accepted (back-to-back transfers allowed).
- start while busy is ignored; it is not queued and has no effect on data_out.
- Watchdog (TIMEOUT>0):
  - Counts +1 per cycle in REQ or REL; cleared on entry to either state.
  - When the count reaches TIMEOUT-1 with the exit condition unmet: next state ERR, timeout_err<=1. The saved return state (REQ or REL) is kept.
  - req_out and data_out are held unchanged in ERR.
  - Exit condition met in the same cycle as expiry: the exit wins; no error.
- ERR: ack_s is ignored. clear_err=1 gives timeout_err<=0, watchdog<=0, return to the saved state. clear_err outside ERR has no effect.
- TIMEOUT=0: the watchdog is held at 0; ERR is unreachable.
- Counter saturates; it never wraps.
- Reset mid-transfer immediately forces the reset values, including req_out=0. In 2-phase mode the listener must be reset together with the talker to restore parity.

Test Plan:
- 4-phase, SYNC_STAGES=2, data_in=0xA5 with start pulse in IDLE -> next cycle req_out=1, data_out=0xA5, ready=0. Raise ack_in -> req_out=0 exactly 3 edges later. Drop ack_in -> done=1 and ready=1 exactly 3 edges later, done lasting 1 cycle.
- 2-phase, SYNC_STAGES=3, two transfers 0x11 then 0x22 -> req_out goes 0->1->0. Each completes 4 edges after the ack_in toggle. start held high in the done cycle starts the second transfer with no idle gap.
- start pulses while busy with data_in=0xFF -> data_out stays 0xA5 and no extra req_out edge occurs.
- TIMEOUT=10, ack_in held 0 after start -> timeout_err=1 and state ERR after 10 cycles in REQ; req_out stays 1. Pulse clear_err, then raise ack_in -> timeout_err=0 and the normal 4-phase completion follows.
- Expiry race: ack_s rises in the same cycle as watchdog expiry -> moves to REL; timeout_err stays 0.
- reset driven 0 for 1 cycle while in REL with req_out=0, data_out=0x5A -> asynchronous return to IDLE: data_out=0, ready=1, done=0, timeout_err=0, without waiting for a clk edge.
